// File: rtl/ram_master_pkg.sv
// Shared types and constants for the ram_master RAM bus initiator.
package ram_master_pkg;

    localparam int unsigned MEM_AW = 12;
    localparam int unsigned MEM_DW = 16;
    localparam int unsigned MEM_LW = 4;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DRAIN = 2'd2,
        READ  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_bus_if.sv
// Registered RAM bus pins (address, rw, write data) and the data-bus tri-state driver.
module ram_bus_if
    import ram_master_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    input  logic          rw_in,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rw,
    output logic [DW-1:0] mem_data_in,
    inout  wire logic [DW-1:0] mem_data
);

    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          rw_q, rw_d;

    // rw is re-registered every cycle so a stalled or finished write never repeats.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        rw_d   = rw_in;
        if (load) begin
            addr_d = addr_in;
            data_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            rw_q   <= RW_READ;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            rw_q   <= rw_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rw      = rw_q;
    assign mem_data    = (rw_q == RW_WRITE) ? data_q : {DW{1'bz}};
    assign mem_data_in = mem_data;

endmodule

// File: rtl/ram_master.sv
// Command/stream to 4096x16 RAM bus initiator with tri-stated data bus.
// Define RAM_MASTER_BURST_EN to honour cmd_len (1..16 beat bursts); otherwise every command is one beat.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int unsigned AW = MEM_AW,
    parameter int unsigned DW = MEM_DW,
    parameter int unsigned LW = MEM_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rw,
    inout  wire logic [DW-1:0] mem_data
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;

    logic          bus_load;
    logic          bus_rw;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] mem_data_in;
    logic          last_beat;

`ifdef RAM_MASTER_BURST_EN
    logic [LW-1:0] beats_q, beats_d;
    assign last_beat = (beats_q == '0);
`else
    logic unused_len;
    assign last_beat  = 1'b1;
    assign unused_len = ^cmd_len;
`endif

    // addr_q always holds the next address to place on the bus.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        bus_load   = 1'b0;
        bus_addr   = addr_q;
        bus_rw     = RW_READ;
`ifdef RAM_MASTER_BURST_EN
        beats_d    = beats_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
`ifdef RAM_MASTER_BURST_EN
                    beats_d = cmd_len;
`endif
                    if (cmd_write) begin
                        state_d = WRITE;
                        addr_d  = cmd_addr;
                    end else begin
                        state_d  = READ;
                        bus_load = 1'b1;
                        bus_addr = cmd_addr;
                        addr_d   = cmd_addr + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    bus_load = 1'b1;
                    bus_rw   = RW_WRITE;
                    addr_d   = addr_q + 1'b1;
                    if (last_beat) begin
                        state_d = DRAIN;
                    end else begin
`ifdef RAM_MASTER_BURST_EN
                        beats_d = beats_q - 1'b1;
`endif
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            READ: begin
                rd_data_d  = mem_data_in;
                rd_valid_d = 1'b1;
                if (last_beat) begin
                    state_d = IDLE;
                end else begin
                    bus_load = 1'b1;
                    addr_d   = addr_q + 1'b1;
`ifdef RAM_MASTER_BURST_EN
                    beats_d  = beats_q - 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef RAM_MASTER_BURST_EN
            beats_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef RAM_MASTER_BURST_EN
            beats_q    <= beats_d;
`endif
        end
    end

    ram_bus_if #(
        .AW (AW),
        .DW (DW)
    ) u_bus (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (bus_load),
        .addr_in     (bus_addr),
        .data_in     (wr_data),
        .rw_in       (bus_rw),
        .mem_addr    (mem_addr),
        .mem_rw      (mem_rw),
        .mem_data_in (mem_data_in),
        .mem_data    (mem_data)
    );

    // Handshake and status outputs are forced low for the whole time rst_n is asserted.
    assign cmd_ready = rst_n && (state_q == IDLE);
    assign wr_ready  = rst_n && (state_q == WRITE);
    assign busy      = rst_n && (state_q != IDLE);
    assign rd_valid  = rst_n && rd_valid_q;
    assign rd_data   = rst_n ? rd_data_q : '0;

endmodule
